// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_tx
// Purpose  : I2S master transmitter for PSG left/right samples; issues the
//            next_sample strobe and latches each sample pair at frame start.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_tx #(
    parameter int BCK_DIV   = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] left_audio,
    input  logic [15:0] right_audio,
    output logic        next_sample,
    output logic        i2s_bck,
    output logic        i2s_lrck,
    output logic        i2s_data
);

    localparam int                 c_div_w    = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int                 c_b_w      = $clog2(2 * SLOT_BITS);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCK_DIV - 1);
    localparam logic [c_b_w-1:0]   c_b_last   = c_b_w'(2 * SLOT_BITS - 1);
    localparam logic [c_b_w-1:0]   c_slot     = c_b_w'(SLOT_BITS);
    localparam logic [c_b_w-1:0]   c_smp_bits = c_b_w'(16);

    logic [c_div_w-1:0] r_div;
    logic [c_b_w-1:0]   r_b;
    logic               r_bck;
    logic               r_lrck;
    logic               r_data;
    logic               r_ns;
    logic [15:0]        r_left;
    logic [15:0]        r_right;

    logic               w_fall;
    logic [c_b_w-1:0]   w_b_next;
    logic [c_b_w-1:0]   w_p;
    logic [15:0]        w_sample;
    logic               w_frame_start;
    logic               w_data;

    // Data lags word select by one BCK, so the bit sent after advancing to
    // b_next belongs to slot position q = b_next-1, which is simply r_b.
    always_comb begin
        w_fall        = (r_div == c_div_last) && r_bck;
        w_b_next      = (r_b == c_b_last) ? '0 : r_b + c_b_w'(1);
        w_frame_start = w_fall && (w_b_next == '0);
        w_p           = (r_b >= c_slot) ? r_b - c_slot : r_b;
        w_sample      = (r_b < c_slot) ? r_left : r_right;
        w_data        = 1'b0;
        if (w_p < c_smp_bits) begin
            w_data = w_sample[~w_p[3:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_b     <= c_b_last;
            r_bck   <= 1'b0;
            r_lrck  <= 1'b0;
            r_data  <= 1'b0;
            r_ns    <= 1'b0;
            r_left  <= '0;
            r_right <= '0;
        end else if (!en) begin
            r_div   <= '0;
            r_b     <= c_b_last;
            r_bck   <= 1'b0;
            r_lrck  <= 1'b0;
            r_data  <= 1'b0;
            r_ns    <= 1'b0;
            r_left  <= '0;
            r_right <= '0;
        end else begin
            r_ns <= w_frame_start;
            if (r_div == c_div_last) begin
                r_div <= '0;
                r_bck <= ~r_bck;
            end else begin
                r_div <= r_div + c_div_w'(1);
            end
            if (w_fall) begin
                r_b    <= w_b_next;
                r_lrck <= (w_b_next >= c_slot);
                r_data <= w_data;
            end
            if (w_frame_start) begin
                r_left  <= left_audio;
                r_right <= right_audio;
            end
        end
    end

    assign next_sample = r_ns;
    assign i2s_bck     = r_bck;
    assign i2s_lrck    = r_lrck;
    assign i2s_data    = r_data;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_i2s_tx
// Purpose  : Randomised bench for audio_i2s_tx (default and minimum geometry)
//            against a clock-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] left_audio  = '0;
    logic [15:0] right_audio = '0;

    logic ns0, bck0, lrck0, data0;
    logic ns1, bck1, lrck1, data1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state per instance: 0 = BCK_DIV 4 / SLOT 32, 1 = BCK_DIV 1 / SLOT 17
    int          k_m[2]    = '{0, 0};
    logic [15:0] lat_l[2]  = '{16'h0, 16'h0};
    logic [15:0] lat_r[2]  = '{16'h0, 16'h0};
    logic        e_bck[2]  = '{1'b0, 1'b0};
    logic        e_lrck[2] = '{1'b0, 1'b0};
    logic        e_data[2] = '{1'b0, 1'b0};
    logic        e_ns[2]   = '{1'b0, 1'b0};
    int          last_ns[2] = '{-1, -1};

    always #5 clk = ~clk;

    audio_i2s_tx #(.BCK_DIV(4), .SLOT_BITS(32)) u_dut0 (
        .clk(clk), .rst(rst), .en(en),
        .left_audio(left_audio), .right_audio(right_audio),
        .next_sample(ns0), .i2s_bck(bck0), .i2s_lrck(lrck0), .i2s_data(data0)
    );

    audio_i2s_tx #(.BCK_DIV(1), .SLOT_BITS(17)) u_dut1 (
        .clk(clk), .rst(rst), .en(en),
        .left_audio(left_audio), .right_audio(right_audio),
        .next_sample(ns1), .i2s_bck(bck1), .i2s_lrck(lrck1), .i2s_data(data1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp_v);
        end
    endtask

    // Outputs after the k-th enabled clock edge, derived from elapsed time:
    // BCK toggles every bd edges, every 2*bd edges is a fall, fall n gives b=n-1.
    task automatic model_step(input int id, input int bd, input int s);
        int          f, b, q, p;
        logic [15:0] smp;
        if (rst || !en) begin
            k_m[id]   = 0;
            lat_l[id] = '0;
            lat_r[id] = '0;
            e_bck[id] = 1'b0;
            e_lrck[id] = 1'b0;
            e_data[id] = 1'b0;
            e_ns[id]  = 1'b0;
        end else begin
            k_m[id]   = k_m[id] + 1;
            e_bck[id] = ((k_m[id] / bd) % 2) == 1;
            e_ns[id]  = 1'b0;
            if ((k_m[id] % (2 * bd)) == 0) begin
                f = k_m[id] / (2 * bd);
                b = (f - 1) % (2 * s);
                q = (b + 2 * s - 1) % (2 * s);
                p = q % s;
                smp = (q < s) ? lat_l[id] : lat_r[id];
                e_lrck[id] = (b >= s);
                e_data[id] = (p < 16) ? smp[15 - p] : 1'b0;
                if (b == 0) begin
                    e_ns[id]  = 1'b1;
                    lat_l[id] = left_audio;
                    lat_r[id] = right_audio;
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        model_step(0, 4, 32);
        model_step(1, 1, 17);
    end

    always @(negedge clk) begin
        cyc++;
        check("bck0",  {31'b0, bck0},  {31'b0, e_bck[0]});
        check("lrck0", {31'b0, lrck0}, {31'b0, e_lrck[0]});
        check("data0", {31'b0, data0}, {31'b0, e_data[0]});
        check("ns0",   {31'b0, ns0},   {31'b0, e_ns[0]});
        check("bck1",  {31'b0, bck1},  {31'b0, e_bck[1]});
        check("lrck1", {31'b0, lrck1}, {31'b0, e_lrck[1]});
        check("data1", {31'b0, data1}, {31'b0, e_data[1]});
        check("ns1",   {31'b0, ns1},   {31'b0, e_ns[1]});
        if (k_m[0] == 0) last_ns[0] = -1;
        if (k_m[1] == 0) last_ns[1] = -1;
        if (ns0) begin
            if (last_ns[0] >= 0) check("ns0_period", cyc - last_ns[0], 512);
            last_ns[0] = cyc;
        end
        if (ns1) begin
            if (last_ns[1] >= 0) check("ns1_period", cyc - last_ns[1], 68);
            last_ns[1] = cyc;
        end
    end

    // Inputs change 1 time unit after the falling edge, clear of both edges.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_phase(input int target);
        for (int i = 0; i < 600; i++) begin
            if ((k_m[0] % 512) == target) break;
            tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        // Known pattern, reset release straight into enabled operation
        left_audio  = 16'h8001;
        right_audio = 16'h7FFE;
        en  = 1'b1;
        rst = 1'b0;
        repeat (1100) tick();

        // Left changes mid-frame at b=20
        left_audio = 16'h1234;
        repeat (600) tick();
        wait_phase(8 * 21);
        left_audio = 16'hABCD;
        repeat (1100) tick();

        // Abort at b=40, then re-enable
        wait_phase(8 * 41);
        en = 1'b0;
        repeat (20) tick();
        en = 1'b1;
        repeat (700) tick();

        // Random samples, random enable drops and one asynchronous reset pulse
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) left_audio  = 16'($urandom);
            if ($urandom_range(0, 15) == 0) right_audio = 16'($urandom);
            if ($urandom_range(0, 1499) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 30)) tick();
                en = 1'b1;
            end
            if (i == 3000) begin
                rst = 1'b1;
                repeat (2) tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
